world_step_scheduler: RTL and testbench
=======================================

Name: world_step_scheduler

Overview:
Sequences one robot step per period against the shared map RAM. Each step reads the current, ahead and left cells through a single synchronous read port, then drives the robot sensors and pulses the robot step enable. It then applies the robot's front/turn/remove response to position, orientation and map. This replaces free-running clock toggling in the world top with an explicit, pausable step schedule.

Parameters:
ROWS, 10, map rows (1-based, 1..ROWS)
COLS, 20, map columns (1-based, 1..COLS)
STEP_DIV, 4, idle cycles inserted between consecutive free-running steps (>=0)
REMOVE_STEPS, 3, consecutive remove responses needed to clear the ahead cell

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  free-run enable
single_step  in  1  pulse; starts exactly one step when idle
init_row / init_column  in  6 each  start position, loaded on reset
init_orientation  in  2  start orientation, loaded on reset
map_rd_addr  out  8  read address, row*COLS+column
map_rd_data  in  3  cell code, valid 1 cycle after address
map_wr_en  out  1  one-cycle map write strobe
map_wr_addr  out  8  write address
map_wr_data  out  3  write data, always 0
head, left, under, barrier  out  1 each  robot sensor inputs
robot_step  out  1  one-cycle enable to robot FSM
front, turn, remove  in  1 each  robot outputs, valid the cycle after robot_step
robot_row, robot_column  out  6 each  current position
robot_orientation  out  2  00 north, 01 south, 10 east, 11 west
busy  out  1  high in every state except IDLE
step_count  out  16  completed steps, wraps at 65535->0

Behaviour:
- Reset (sync, high): state IDLE; position and orientation loaded from init_*; all sensor outputs, robot_step, map_wr_en, busy = 0; remove counter = 0; step_count = 0; map_rd_addr = 0. Reset mid-step aborts the step with no map write and no position update.
- Cell codes: 0 empty, 1 wall, 2 barrier, 7 trash.
- Ahead cell by orientation: N (r-1,c), S (r+1,c), E (r,c+1), W (r,c-1).
- Left cell by orientation: N (r,c-1), S (r,c+1), E (r-1,c), W (r+1,c).
- Border: a cell is off-map if its row is outside 1..ROWS or its column is outside 1..COLS. For an off-map cell the read is suppressed (address held) and the data is ignored.
- FSM: IDLE -> RD_UNDER -> RD_AHEAD -> RD_LEFT -> LATCH -> STEP -> APPLY -> WAIT.
  - IDLE: run=1 or single_step=1 -> RD_UNDER.
  - RD_UNDER: issues the current-cell address.
  - RD_AHEAD: issues the ahead address and captures under.
  - RD_LEFT: issues the left address and captures ahead.
  - LATCH: captures left; registers head/left/under/barrier.
  - STEP: robot_step=1 for exactly one cycle.
  - APPLY: samples front/turn/remove and updates state.
  - WAIT: counts STEP_DIV cycles, then goes to RD_UNDER if run=1, else IDLE.
- Sensor rules:
  - head = ahead off-map or ahead==1.
  - left = left off-map or left==1.
  - under = current==7.
  - barrier = ahead on-map and ahead==2.
  - Sensors hold their values until the next LATCH.
- APPLY rules:
  - front=1 and head=0 and barrier=0: move one cell toward ahead.
  - front=1 while blocked: no change.
  - Otherwise turn=1: rotate left (N->W, W->S, S->E, E->N).
  - front and turn both 1: front wins.
  - step_count increments every APPLY.
  - Position/orientation change is visible the cycle after APPLY.
- Remove rules:
  - remove=1 in APPLY increments the counter.
  - When the counter reaches REMOVE_STEPS, map_wr_en=1 that same cycle with the ahead address and data 0, and the counter resets to 0. If the ahead cell is off-map, no write occurs but the counter still resets.
  - remove=0 in APPLY resets the counter.
- single_step while busy is ignored. Dropping run mid-step completes the current step, then returns to IDLE after WAIT.
- Latency: single_step at cycle 0 -> robot_step at cycle 5, APPLY at cycle 6, new position at cycle 7. Free-running step period = 6+STEP_DIV cycles.

Decomposition:
- Package world_pkg holds:
  - orientation constants NORTH/SOUTH/EAST/WEST
  - cell codes EMPTY/WALL/BARRIER/TRASH
  - default ROWS/COLS
  - map_addr(row,col) function
  - left_turn(orient) function
- One combinational sub-module, world_neighbour_calc: takes row/column/orientation and produces the current/ahead/left addresses, off-map flags and the next position if moving. It is shared with the VGA renderer's robot overlay.

Test Plan:
- init (5,5) N, map(4,5)=0, single_step, robot front=1 -> single robot_step pulse at cycle 5; robot_row=4 at cycle 7; step_count=1; busy low after WAIT.
- init (1,1) N -> head=1, left=1, barrier=0, no read of row 0; front=1 forced -> position stays (1,1).
- init (3,6) E, map(3,7)=2 -> barrier=1; remove=1 for 3 steps -> map_wr_en single pulse at 3rd APPLY, addr 67, data 0. Repeat with remove pattern 1,1,0,1,1,1 -> write only at the 6th step.
- current cell=7 -> under=1; init E with turn=1 -> orientation 00, position unchanged; front=turn=1 -> move wins.
- run=1, STEP_DIV=4 -> robot_step every 10 cycles; drop run during RD_LEFT -> that step completes, then IDLE; single_step during busy -> no extra step.
- assert reset during RD_AHEAD -> IDLE next cycle, position = init_*, step_count=0, no map_wr_en.

Source files
------------

// File: rtl/world_pkg.sv
// Shared types, constants and helpers for the robot world: cell codes,
// orientations, map addressing and the left-rotate rule.
package world_pkg;

    localparam int unsigned DEF_ROWS = 10;
    localparam int unsigned DEF_COLS = 20;
    localparam int unsigned POS_W    = 6;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned CELL_W   = 3;

    typedef enum logic [1:0] {
        NORTH = 2'b00,
        SOUTH = 2'b01,
        EAST  = 2'b10,
        WEST  = 2'b11
    } orient_t;

    typedef enum logic [CELL_W-1:0] {
        EMPTY   = 3'd0,
        WALL    = 3'd1,
        BARRIER = 3'd2,
        TRASH   = 3'd7
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_UNDER,
        ST_RD_AHEAD,
        ST_RD_LEFT,
        ST_LATCH,
        ST_STEP,
        ST_APPLY,
        ST_WAIT
    } step_state_t;

    typedef struct packed {
        logic head;
        logic left;
        logic under;
        logic barrier;
    } sensors_t;

    // Linear map address of a 1-based (row, col) cell.
    function automatic logic [ADDR_W-1:0] map_addr(input logic [POS_W-1:0] row,
                                                   input logic [POS_W-1:0] col,
                                                   input int unsigned      cols = DEF_COLS);
        return ADDR_W'(32'(row) * cols + 32'(col));
    endfunction

    function automatic orient_t left_turn(input orient_t orient);
        case (orient)
            NORTH:   return WEST;
            WEST:    return SOUTH;
            SOUTH:   return EAST;
            default: return NORTH;
        endcase
    endfunction

endpackage

// File: rtl/world_step_scheduler_if.sv
// Bundle between the step scheduler and the world (map RAM, robot FSM,
// control and status).
interface world_step_scheduler_if;
    import world_pkg::*;

    logic                 run;
    logic                 single_step;
    logic [POS_W-1:0]     init_row;
    logic [POS_W-1:0]     init_column;
    logic [1:0]           init_orientation;

    logic [ADDR_W-1:0]    map_rd_addr;
    logic [CELL_W-1:0]    map_rd_data;
    logic                 map_wr_en;
    logic [ADDR_W-1:0]    map_wr_addr;
    logic [CELL_W-1:0]    map_wr_data;

    logic                 head;
    logic                 left;
    logic                 under;
    logic                 barrier;
    logic                 robot_step;
    logic                 front;
    logic                 turn;
    logic                 remove;

    logic [POS_W-1:0]     robot_row;
    logic [POS_W-1:0]     robot_column;
    logic [1:0]           robot_orientation;
    logic                 busy;
    logic [15:0]          step_count;

    modport master (
        input  run, single_step, init_row, init_column, init_orientation,
               map_rd_data, front, turn, remove,
        output map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
               head, left, under, barrier, robot_step,
               robot_row, robot_column, robot_orientation, busy, step_count
    );

    modport slave (
        output run, single_step, init_row, init_column, init_orientation,
               map_rd_data, front, turn, remove,
        input  map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
               head, left, under, barrier, robot_step,
               robot_row, robot_column, robot_orientation, busy, step_count
    );

endinterface

// File: rtl/world_neighbour_calc.sv
// Combinational neighbourhood of a robot pose: current/ahead/left addresses,
// off-map flags for ahead/left and the position reached by moving ahead.
module world_neighbour_calc
    import world_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS
) (
    input  logic [POS_W-1:0]  i_row,
    input  logic [POS_W-1:0]  i_col,
    input  orient_t           i_orient,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic [ADDR_W-1:0] o_ahead_addr,
    output logic [ADDR_W-1:0] o_left_addr,
    output logic              o_ahead_off,
    output logic              o_left_off,
    output logic [POS_W-1:0]  o_next_row,
    output logic [POS_W-1:0]  o_next_col
);

    localparam int unsigned EXT_W = POS_W + 1;
    localparam logic [EXT_W-1:0] ROWS_L = EXT_W'(ROWS);
    localparam logic [EXT_W-1:0] COLS_L = EXT_W'(COLS);
    localparam logic [EXT_W-1:0] ONE_L  = EXT_W'(1);

    logic [EXT_W-1:0] w_row;
    logic [EXT_W-1:0] w_col;
    logic [EXT_W-1:0] w_ahead_r;
    logic [EXT_W-1:0] w_ahead_c;
    logic [EXT_W-1:0] w_left_r;
    logic [EXT_W-1:0] w_left_c;

    // One extra bit lets row/col 0 - 1 wrap far outside the map instead of aliasing.
    function automatic logic on_map(input logic [EXT_W-1:0] r, input logic [EXT_W-1:0] c);
        return (r >= ONE_L) && (r <= ROWS_L) && (c >= ONE_L) && (c <= COLS_L);
    endfunction

    assign w_row = EXT_W'(i_row);
    assign w_col = EXT_W'(i_col);

    always_comb begin
        w_ahead_r = w_row;
        w_ahead_c = w_col;
        w_left_r  = w_row;
        w_left_c  = w_col;
        case (i_orient)
            NORTH: begin w_ahead_r = w_row - ONE_L; w_left_c = w_col - ONE_L; end
            SOUTH: begin w_ahead_r = w_row + ONE_L; w_left_c = w_col + ONE_L; end
            EAST:  begin w_ahead_c = w_col + ONE_L; w_left_r = w_row - ONE_L; end
            default: begin w_ahead_c = w_col - ONE_L; w_left_r = w_row + ONE_L; end
        endcase
    end

    assign o_ahead_off  = !on_map(w_ahead_r, w_ahead_c);
    assign o_left_off   = !on_map(w_left_r, w_left_c);
    assign o_next_row   = POS_W'(w_ahead_r);
    assign o_next_col   = POS_W'(w_ahead_c);
    assign o_cur_addr   = map_addr(i_row, i_col, COLS);
    assign o_ahead_addr = map_addr(POS_W'(w_ahead_r), POS_W'(w_ahead_c), COLS);
    assign o_left_addr  = map_addr(POS_W'(w_left_r), POS_W'(w_left_c), COLS);

endmodule

// File: rtl/world_step_scheduler.sv
// Runs one robot step per period: reads under/ahead/left cells, latches the
// sensors, pulses robot_step, then applies the move/turn/remove response.
module world_step_scheduler
    import world_pkg::*;
#(
    parameter int unsigned ROWS         = DEF_ROWS,
    parameter int unsigned COLS         = DEF_COLS,
    parameter int unsigned STEP_DIV     = 4,
    parameter int unsigned REMOVE_STEPS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    world_step_scheduler_if.master bus
);

    localparam int unsigned WAIT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned RM_W   = (REMOVE_STEPS > 1) ? $clog2(REMOVE_STEPS) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STEP_DIV - 1);
    localparam logic [RM_W-1:0]   RM_LAST   = RM_W'(REMOVE_STEPS - 1);

    step_state_t         r_state;
    logic [POS_W-1:0]    r_row;
    logic [POS_W-1:0]    r_col;
    orient_t             r_orient;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [CELL_W-1:0]   r_cell_under;
    logic [CELL_W-1:0]   r_cell_ahead;
    sensors_t            r_sens;
    logic                r_robot_step;
    logic                r_busy;
    logic [15:0]         r_step_count;
    logic [RM_W-1:0]     r_rm_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;

    logic [ADDR_W-1:0]   w_cur_addr;
    logic [ADDR_W-1:0]   w_ahead_addr;
    logic [ADDR_W-1:0]   w_left_addr;
    logic                w_ahead_off;
    logic                w_left_off;
    logic [POS_W-1:0]    w_next_row;
    logic [POS_W-1:0]    w_next_col;
    logic                w_move;
    logic                w_rm_hit;
    logic [ADDR_W-1:0]   w_restart_addr;

    world_neighbour_calc #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_neighbour (
        .i_row        (r_row),
        .i_col        (r_col),
        .i_orient     (r_orient),
        .o_cur_addr   (w_cur_addr),
        .o_ahead_addr (w_ahead_addr),
        .o_left_addr  (w_left_addr),
        .o_ahead_off  (w_ahead_off),
        .o_left_off   (w_left_off),
        .o_next_row   (w_next_row),
        .o_next_col   (w_next_col)
    );

    assign w_move   = bus.front && !r_sens.head && !r_sens.barrier;
    assign w_rm_hit = (r_state == ST_APPLY) && bus.remove && (r_rm_cnt == RM_LAST);
    // Only used when there is no WAIT state: the next step starts from the post-move cell.
    assign w_restart_addr = w_move ? map_addr(w_next_row, w_next_col, COLS) : w_cur_addr;

    // The clear strobe fires in the APPLY cycle itself, so it is decoded, not registered.
    assign bus.map_wr_en   = w_rm_hit && !w_ahead_off && !reset;
    assign bus.map_wr_addr = w_ahead_addr;
    assign bus.map_wr_data = CELL_W'(EMPTY);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_row        <= bus.init_row;
            r_col        <= bus.init_column;
            r_orient     <= orient_t'(bus.init_orientation);
            r_rd_addr    <= '0;
            r_cell_under <= '0;
            r_cell_ahead <= '0;
            r_sens       <= '0;
            r_robot_step <= 1'b0;
            r_busy       <= 1'b0;
            r_step_count <= '0;
            r_rm_cnt     <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_robot_step <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.run || bus.single_step) begin
                        r_state   <= ST_RD_UNDER;
                        r_rd_addr <= w_cur_addr;
                        r_busy    <= 1'b1;
                    end
                end
                ST_RD_UNDER: begin
                    r_state <= ST_RD_AHEAD;
                    if (!w_ahead_off) r_rd_addr <= w_ahead_addr;
                end
                ST_RD_AHEAD: begin
                    r_state      <= ST_RD_LEFT;
                    r_cell_under <= bus.map_rd_data;
                    if (!w_left_off) r_rd_addr <= w_left_addr;
                end
                ST_RD_LEFT: begin
                    r_state      <= ST_LATCH;
                    r_cell_ahead <= bus.map_rd_data;
                end
                ST_LATCH: begin
                    r_state        <= ST_STEP;
                    r_sens.head    <= w_ahead_off || (r_cell_ahead == WALL);
                    r_sens.left    <= w_left_off || (bus.map_rd_data == WALL);
                    r_sens.under   <= (r_cell_under == TRASH);
                    r_sens.barrier <= !w_ahead_off && (r_cell_ahead == BARRIER);
                    r_robot_step   <= 1'b1;
                end
                ST_STEP: begin
                    r_state <= ST_APPLY;
                end
                ST_APPLY: begin
                    r_step_count <= r_step_count + 16'd1;
                    if (bus.front) begin
                        if (w_move) begin
                            r_row <= w_next_row;
                            r_col <= w_next_col;
                        end
                    end else if (bus.turn) begin
                        r_orient <= left_turn(r_orient);
                    end
                    if (!bus.remove || (r_rm_cnt == RM_LAST)) r_rm_cnt <= '0;
                    else                                       r_rm_cnt <= r_rm_cnt + RM_W'(1);
                    r_wait_cnt <= '0;
                    if (STEP_DIV > 0) begin
                        r_state <= ST_WAIT;
                    end else if (bus.run) begin
                        r_state   <= ST_RD_UNDER;
                        r_rd_addr <= w_restart_addr;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        if (bus.run) begin
                            r_state   <= ST_RD_UNDER;
                            r_rd_addr <= w_cur_addr;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.map_rd_addr       = r_rd_addr;
    assign bus.head              = r_sens.head;
    assign bus.left              = r_sens.left;
    assign bus.under             = r_sens.under;
    assign bus.barrier           = r_sens.barrier;
    assign bus.robot_step        = r_robot_step;
    assign bus.robot_row         = r_row;
    assign bus.robot_column      = r_col;
    assign bus.robot_orientation = r_orient;
    assign bus.busy              = r_busy;
    assign bus.step_count        = r_step_count;

endmodule

// File: tb/tb_world_step_scheduler.sv
// Directed bench for world_step_scheduler with a small synchronous map RAM model.
module tb_world_step_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;

    world_step_scheduler_if bus();

    world_step_scheduler #(
        .ROWS         (10),
        .COLS         (20),
        .STEP_DIV     (4),
        .REMOVE_STEPS (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Map RAM: one synchronous read port, the DUT write port and a bench poke port.
    bit   [2:0] mem [0:255];
    logic       poke_en   = 1'b0;
    logic [7:0] poke_addr = '0;
    logic [2:0] poke_data = '0;

    always @(posedge clock) begin
        bus.map_rd_data <= mem[bus.map_rd_addr];
        if (bus.map_wr_en)  mem[bus.map_wr_addr] <= bus.map_wr_data;
        else if (poke_en)   mem[poke_addr]       <= poke_data;
    end

    // Event log sampled on the edge that ends each cycle.
    int cyc     = 0;
    int rs_cnt  = 0;
    int wr_cnt  = 0;
    int rs_times[$];
    logic [7:0] wr_addr_last = '0;
    logic [2:0] wr_data_last = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.robot_step) begin
            rs_cnt <= rs_cnt + 1;
            rs_times.push_back(cyc);
        end
        if (bus.map_wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_last <= bus.map_wr_addr;
            wr_data_last <= bus.map_wr_data;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [2:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic set_resp(input logic f, input logic t, input logic r);
        bus.front  = f;
        bus.turn   = t;
        bus.remove = r;
    endtask

    task automatic do_reset(input logic [5:0] r, input logic [5:0] c, input logic [1:0] o);
        bus.init_row         = r;
        bus.init_column      = c;
        bus.init_orientation = o;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One single-step, then wait for the scheduler to return to idle.
    task automatic do_step(input string tag);
        int n;
        bus.single_step = 1'b1;
        tick();
        bus.single_step = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check_eq({tag, "_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    int base_rs;
    int base_wr;
    int n;

    initial begin
        bus.run = 1'b0;
        bus.single_step = 1'b0;
        set_resp(1'b0, 1'b0, 1'b0);

        // Move north from (5,5) on an empty map, cycle-accurate.
        set_resp(1'b1, 1'b0, 1'b0);
        do_reset(6'd5, 6'd5, 2'b00);
        check_eq("rst_busy",   32'(bus.busy), 32'd0);
        check_eq("rst_rstep",  32'(bus.robot_step), 32'd0);
        check_eq("rst_count",  32'(bus.step_count), 32'd0);
        check_eq("rst_rdaddr", 32'(bus.map_rd_addr), 32'd0);
        check_eq("rst_row",    32'(bus.robot_row), 32'd5);
        check_eq("rst_col",    32'(bus.robot_column), 32'd5);
        check_eq("rst_orient", 32'(bus.robot_orientation), 32'd0);
        check_eq("rst_wren",   32'(bus.map_wr_en), 32'd0);
        base_rs = rs_cnt;
        bus.single_step = 1'b1;
        tick();
        bus.single_step = 1'b0;
        check_eq("t1_addr_cur",   32'(bus.map_rd_addr), 32'd105);
        tick();
        check_eq("t1_addr_ahead", 32'(bus.map_rd_addr), 32'd85);
        tick();
        check_eq("t1_addr_left",  32'(bus.map_rd_addr), 32'd104);
        tick();
        check_eq("t1_rstep_c4",   32'(bus.robot_step), 32'd0);
        tick();
        check_eq("t1_rstep_c5",   32'(bus.robot_step), 32'd1);
        check_eq("t1_head",       32'(bus.head), 32'd0);
        tick();
        check_eq("t1_rstep_c6",   32'(bus.robot_step), 32'd0);
        check_eq("t1_row_c6",     32'(bus.robot_row), 32'd5);
        tick();
        check_eq("t1_row_c7",     32'(bus.robot_row), 32'd4);
        check_eq("t1_count_c7",   32'(bus.step_count), 32'd1);
        tick(); tick(); tick();
        check_eq("t1_busy_c10",   32'(bus.busy), 32'd1);
        tick();
        check_eq("t1_busy_c11",   32'(bus.busy), 32'd0);
        check_eq("t1_rs_pulses",  32'(rs_cnt - base_rs), 32'd1);

        // Corner (1,1) facing north: both neighbours off-map, reads held.
        set_resp(1'b1, 1'b0, 1'b0);
        do_reset(6'd1, 6'd1, 2'b00);
        bus.single_step = 1'b1;
        tick();
        bus.single_step = 1'b0;
        check_eq("t2_addr_c1", 32'(bus.map_rd_addr), 32'd21);
        tick();
        check_eq("t2_addr_c2", 32'(bus.map_rd_addr), 32'd21);
        tick();
        check_eq("t2_addr_c3", 32'(bus.map_rd_addr), 32'd21);
        tick(); tick();
        check_eq("t2_head",    32'(bus.head), 32'd1);
        check_eq("t2_left",    32'(bus.left), 32'd1);
        check_eq("t2_barrier", 32'(bus.barrier), 32'd0);
        n = 0;
        while (bus.busy && n < 40) begin tick(); n++; end
        check_eq("t2_row",     32'(bus.robot_row), 32'd1);
        check_eq("t2_col",     32'(bus.robot_column), 32'd1);

        // Barrier ahead at (3,7); remove three times clears it.
        poke(8'd67, 3'd2);
        set_resp(1'b0, 1'b0, 1'b1);
        do_reset(6'd3, 6'd6, 2'b10);
        base_wr = wr_cnt;
        do_step("t3_s1");
        check_eq("t3_barrier", 32'(bus.barrier), 32'd1);
        check_eq("t3_head",    32'(bus.head), 32'd0);
        do_step("t3_s2");
        check_eq("t3_wr_s2",   32'(wr_cnt - base_wr), 32'd0);
        do_step("t3_s3");
        check_eq("t3_wr_s3",   32'(wr_cnt - base_wr), 32'd1);
        check_eq("t3_wr_addr", 32'(wr_addr_last), 32'd67);
        check_eq("t3_wr_data", 32'(wr_data_last), 32'd0);
        check_eq("t3_col",     32'(bus.robot_column), 32'd6);

        // Remove pattern 1,1,0,1,1,1: only the sixth step writes.
        poke(8'd67, 3'd2);
        base_wr = wr_cnt;
        set_resp(1'b0, 1'b0, 1'b1); do_step("t3_p1");
        set_resp(1'b0, 1'b0, 1'b1); do_step("t3_p2");
        set_resp(1'b0, 1'b0, 1'b0); do_step("t3_p3");
        set_resp(1'b0, 1'b0, 1'b1); do_step("t3_p4");
        set_resp(1'b0, 1'b0, 1'b1); do_step("t3_p5");
        check_eq("t3_pat_wr5", 32'(wr_cnt - base_wr), 32'd0);
        set_resp(1'b0, 1'b0, 1'b1); do_step("t3_p6");
        check_eq("t3_pat_wr6", 32'(wr_cnt - base_wr), 32'd1);

        // Trash underfoot, left turn from east, then front beats turn.
        poke(8'd66, 3'd7);
        set_resp(1'b0, 1'b1, 1'b0);
        do_reset(6'd3, 6'd6, 2'b10);
        do_step("t4_turn");
        check_eq("t4_under",   32'(bus.under), 32'd1);
        check_eq("t4_orient",  32'(bus.robot_orientation), 32'd0);
        check_eq("t4_row",     32'(bus.robot_row), 32'd3);
        check_eq("t4_col",     32'(bus.robot_column), 32'd6);
        set_resp(1'b1, 1'b1, 1'b0);
        do_step("t4_both");
        check_eq("t4_both_row",    32'(bus.robot_row), 32'd2);
        check_eq("t4_both_orient", 32'(bus.robot_orientation), 32'd0);
        check_eq("t4_count",       32'(bus.step_count), 32'd2);

        // Free run: period 10, drop run in RD_LEFT of the third step.
        set_resp(1'b0, 1'b0, 1'b0);
        do_reset(6'd5, 6'd5, 2'b00);
        base_rs = rs_cnt;
        bus.run = 1'b1;
        n = 0;
        while (rs_cnt - base_rs < 2 && n < 60) begin tick(); n++; end
        check_eq("t5_two_steps", 32'(rs_cnt - base_rs), 32'd2);
        if (rs_cnt - base_rs >= 2)
            check_eq("t5_period", 32'(rs_times[base_rs + 1] - rs_times[base_rs]), 32'd10);
        repeat (7) tick();
        bus.run = 1'b0;
        bus.single_step = 1'b1;
        tick();
        bus.single_step = 1'b0;
        n = 1;
        while (bus.busy && n < 40) begin tick(); n++; end
        check_eq("t5_idle_after", 32'(n), 32'd8);
        repeat (25) tick();
        check_eq("t5_steps",  32'(rs_cnt - base_rs), 32'd3);
        check_eq("t5_count",  32'(bus.step_count), 32'd3);
        if (rs_cnt - base_rs >= 3)
            check_eq("t5_period2", 32'(rs_times[base_rs + 2] - rs_times[base_rs + 1]), 32'd10);

        // Reset during RD_AHEAD aborts the pending third remove.
        poke(8'd67, 3'd2);
        set_resp(1'b0, 1'b0, 1'b1);
        do_reset(6'd3, 6'd6, 2'b10);
        do_step("t6_s1");
        do_step("t6_s2");
        base_wr = wr_cnt;
        base_rs = rs_cnt;
        bus.single_step = 1'b1;
        tick();
        bus.single_step = 1'b0;
        tick();
        bus.init_row         = 6'd7;
        bus.init_column      = 6'd8;
        bus.init_orientation = 2'b11;
        reset = 1'b1;
        tick();
        check_eq("t6_busy",   32'(bus.busy), 32'd0);
        check_eq("t6_row",    32'(bus.robot_row), 32'd7);
        check_eq("t6_col",    32'(bus.robot_column), 32'd8);
        check_eq("t6_orient", 32'(bus.robot_orientation), 32'd3);
        check_eq("t6_count",  32'(bus.step_count), 32'd0);
        reset = 1'b0;
        repeat (12) tick();
        check_eq("t6_no_rs", 32'(rs_cnt - base_rs), 32'd0);
        check_eq("t6_no_wr", 32'(wr_cnt - base_wr), 32'd0);
        do_step("t6_s3");
        check_eq("t6_no_wr_after", 32'(wr_cnt - base_wr), 32'd0);
        check_eq("t6_count_after", 32'(bus.step_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
